hft_order_gate: RTL and testbench

Downstream stage of the 0+ strategy core. Captures each strategy decision (action/price/quantity, qualified by the core's done pulse), applies pre-trade risk checks (action legality, quantity cap, position limit, price sanity), and emits at most one outstanding order to the exchange-interface stage over a valid/ready handshake. After each order it waits for an exchange ack or a timeout, then enforces a cooldown before accepting the next decision.

---
 rtl/hft_pkg.sv | 22 ++
 rtl/hft_risk_check.sv | 43 ++++
 rtl/hft_order_gate.sv | 184 ++++++++++++++++++
 tb/tb_hft_order_gate.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/hft_pkg.sv
// Shared encodings, default limits and gate FSM state type for the order-gate family.
package hft_pkg;

   localparam int unsigned ACT_HOLD = 0;
   localparam int unsigned ACT_BUY  = 1;
   localparam int unsigned ACT_SELL = 2;

   localparam logic SIDE_BUY  = 1'b0;
   localparam logic SIDE_SELL = 1'b1;

   localparam int unsigned MAX_QTY_DEFAULT = 100;
   localparam int unsigned MAX_POS_DEFAULT = 100;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CHECK,
      ST_SEND,
      ST_WAIT_ACK,
      ST_COOLDOWN
   } gate_state_t;

endpackage

// File: rtl/hft_risk_check.sv
// Combinational pre-trade risk check: action legality, quantity cap, price sanity and
// post-fill absolute position limit.
module hft_risk_check
   import hft_pkg::*;
#(
   parameter int          DATA_WIDTH = 32,
   parameter int unsigned MAX_QTY    = MAX_QTY_DEFAULT,
   parameter int unsigned MAX_POS    = MAX_POS_DEFAULT
)(
   input  logic [DATA_WIDTH-1:0] action,
   input  logic [DATA_WIDTH-1:0] price,
   input  logic [DATA_WIDTH-1:0] qty,
   input  logic [DATA_WIDTH-1:0] position,
   output logic                  pass
);

   localparam int EW = DATA_WIDTH + 2;

   logic                 is_buy;
   logic                 is_sell;
   logic                 qty_ok;
   logic                 price_ok;
   logic                 pos_ok;
   logic signed [EW-1:0] pos_ext;
   logic signed [EW-1:0] qty_ext;
   logic signed [EW-1:0] post_fill;
   logic signed [EW-1:0] lim;

   // Two guard bits make position +/- qty exact for any input combination.
   always_comb begin
      is_buy    = (action == DATA_WIDTH'(ACT_BUY));
      is_sell   = (action == DATA_WIDTH'(ACT_SELL));
      pos_ext   = {{2{position[DATA_WIDTH-1]}}, position};
      qty_ext   = {2'b00, qty};
      lim       = EW'(MAX_POS);
      post_fill = is_buy ? (pos_ext + qty_ext) : (pos_ext - qty_ext);
      qty_ok    = (qty != '0) && (qty <= DATA_WIDTH'(MAX_QTY));
      price_ok  = (price != '0);
      pos_ok    = (post_fill <= lim) && (post_fill >= -lim);
      pass      = (is_buy || is_sell) && qty_ok && price_ok && pos_ok;
   end

endmodule

// File: rtl/hft_order_gate.sv
// Order gate: captures strategy decisions, risk-checks them, issues one outstanding order
// over valid/ready, then waits for ack or timeout and enforces a cooldown.
module hft_order_gate
   import hft_pkg::*;
#(
   parameter int          DATA_WIDTH   = 32,
   parameter int unsigned MAX_QTY      = MAX_QTY_DEFAULT,
   parameter int unsigned MAX_POS      = MAX_POS_DEFAULT,
   parameter int unsigned COOLDOWN_CYC = 4,
   parameter int unsigned ACK_TIMEOUT  = 64,
   parameter int          ID_WIDTH     = 16,
   parameter int          CNT_WIDTH    = 16
)(
   input  logic                  ap_clk,
   input  logic                  ap_rst_n,
   input  logic                  dec_valid,
   input  logic [DATA_WIDTH-1:0] dec_action,
   input  logic [DATA_WIDTH-1:0] dec_price,
   input  logic [DATA_WIDTH-1:0] dec_qty,
   input  logic [DATA_WIDTH-1:0] current_position,
   output logic                  ord_valid,
   input  logic                  ord_ready,
   output logic                  ord_side,
   output logic [DATA_WIDTH-1:0] ord_price,
   output logic [DATA_WIDTH-1:0] ord_qty,
   output logic [ID_WIDTH-1:0]   ord_id,
   input  logic                  ack_valid,
   output logic                  busy,
   output logic [CNT_WIDTH-1:0]  sent_count,
   output logic [CNT_WIDTH-1:0]  reject_count,
   output logic [CNT_WIDTH-1:0]  drop_count,
   output logic [CNT_WIDTH-1:0]  timeout_count
);

   localparam int TMR_W = $clog2(ACK_TIMEOUT + 1);
   localparam int CD_W  = $clog2(COOLDOWN_CYC + 2);
   localparam int NCNT  = 4;

   gate_state_t             state_q, state_d;
   logic [DATA_WIDTH-1:0]   act_q, act_d, price_q, price_d, qty_q, qty_d, pos_q, pos_d;
   logic [TMR_W-1:0]        tmr_q, tmr_d;
   logic [CD_W-1:0]         cd_q, cd_d;
   logic                    ord_valid_q, ord_valid_d, ord_side_q, ord_side_d;
   logic [DATA_WIDTH-1:0]   ord_price_q, ord_price_d, ord_qty_q, ord_qty_d;
   logic [ID_WIDTH-1:0]     ord_id_q, ord_id_d;
   logic [NCNT-1:0]         cnt_inc;
   logic [NCNT*CNT_WIDTH-1:0] cnt_flat;
   logic                    risk_pass, dec_legal, dec_trade, ack_expired;

   hft_risk_check #(
      .DATA_WIDTH (DATA_WIDTH),
      .MAX_QTY    (MAX_QTY),
      .MAX_POS    (MAX_POS)
   ) u_risk (
      .action   (act_q),
      .price    (price_q),
      .qty      (qty_q),
      .position (pos_q),
      .pass     (risk_pass)
   );

   assign dec_legal   = (dec_action == DATA_WIDTH'(ACT_BUY)) || (dec_action == DATA_WIDTH'(ACT_SELL));
   assign dec_trade   = dec_valid && (dec_action != DATA_WIDTH'(ACT_HOLD));
   assign ack_expired = (tmr_q == TMR_W'(ACK_TIMEOUT - 1));

   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         state_q     <= ST_IDLE;
         act_q       <= '0;
         price_q     <= '0;
         qty_q       <= '0;
         pos_q       <= '0;
         tmr_q       <= '0;
         cd_q        <= '0;
         ord_valid_q <= 1'b0;
         ord_side_q  <= 1'b0;
         ord_price_q <= '0;
         ord_qty_q   <= '0;
         ord_id_q    <= '0;
      end else begin
         state_q     <= state_d;
         act_q       <= act_d;
         price_q     <= price_d;
         qty_q       <= qty_d;
         pos_q       <= pos_d;
         tmr_q       <= tmr_d;
         cd_q        <= cd_d;
         ord_valid_q <= ord_valid_d;
         ord_side_q  <= ord_side_d;
         ord_price_q <= ord_price_d;
         ord_qty_q   <= ord_qty_d;
         ord_id_q    <= ord_id_d;
      end
   end

   always_comb begin
      state_d = state_q;
      tmr_d   = tmr_q;
      cd_d    = cd_q;
      case (state_q)
         ST_IDLE:     if (dec_valid && dec_legal) state_d = ST_CHECK;
         ST_CHECK:    state_d = risk_pass ? ST_SEND : ST_IDLE;
         ST_SEND: begin
            if (ord_ready) begin
               state_d = ST_WAIT_ACK;
               tmr_d   = '0;
            end
         end
         ST_WAIT_ACK: begin
            if (ack_valid || ack_expired) begin
               state_d = (COOLDOWN_CYC == 0) ? ST_IDLE : ST_COOLDOWN;
               cd_d    = '0;
            end else begin
               tmr_d = tmr_q + TMR_W'(1);
            end
         end
         ST_COOLDOWN: begin
            if (cd_q == CD_W'(COOLDOWN_CYC - 1)) state_d = ST_IDLE;
            else                                  cd_d    = cd_q + CD_W'(1);
         end
         default:     state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      act_d       = act_q;
      price_d     = price_q;
      qty_d       = qty_q;
      pos_d       = pos_q;
      ord_valid_d = ord_valid_q;
      ord_side_d  = ord_side_q;
      ord_price_d = ord_price_q;
      ord_qty_d   = ord_qty_q;
      ord_id_d    = ord_id_q;
      cnt_inc     = '0;
      if (state_q == ST_IDLE && dec_valid && dec_legal) begin
         act_d   = dec_action;
         price_d = dec_price;
         qty_d   = dec_qty;
         pos_d   = current_position;
      end
      if (state_q == ST_CHECK && risk_pass) begin
         ord_valid_d = 1'b1;
         ord_side_d  = (act_q == DATA_WIDTH'(ACT_SELL)) ? SIDE_SELL : SIDE_BUY;
         ord_price_d = price_q;
         ord_qty_d   = qty_q;
      end
      if (state_q == ST_SEND && ord_ready) begin
         ord_valid_d = 1'b0;
         ord_id_d    = ord_id_q + ID_WIDTH'(1);
      end
      cnt_inc[0] = (state_q == ST_SEND) && ord_ready;
      cnt_inc[1] = ((state_q == ST_IDLE) && dec_trade && !dec_legal) ||
                   ((state_q == ST_CHECK) && !risk_pass);
      cnt_inc[2] = (state_q != ST_IDLE) && dec_trade;
      cnt_inc[3] = (state_q == ST_WAIT_ACK) && !ack_valid && ack_expired;
   end

   // Saturating statistics counters: 0 sent, 1 reject, 2 drop, 3 timeout.
   for (genvar gi = 0; gi < NCNT; gi++) begin : g_cnt
      logic [CNT_WIDTH-1:0] c_q, c_d;
      always_comb begin
         c_d = c_q;
         if (cnt_inc[gi] && (c_q != '1)) c_d = c_q + CNT_WIDTH'(1);
      end
      always_ff @(posedge ap_clk or negedge ap_rst_n) begin
         if (!ap_rst_n) c_q <= '0;
         else           c_q <= c_d;
      end
      assign cnt_flat[gi*CNT_WIDTH +: CNT_WIDTH] = c_q;
   end

   assign ord_valid     = ord_valid_q;
   assign ord_side      = ord_side_q;
   assign ord_price     = ord_price_q;
   assign ord_qty       = ord_qty_q;
   assign ord_id        = ord_id_q;
   assign busy          = (state_q != ST_IDLE);
   assign sent_count    = cnt_flat[0*CNT_WIDTH +: CNT_WIDTH];
   assign reject_count  = cnt_flat[1*CNT_WIDTH +: CNT_WIDTH];
   assign drop_count    = cnt_flat[2*CNT_WIDTH +: CNT_WIDTH];
   assign timeout_count = cnt_flat[3*CNT_WIDTH +: CNT_WIDTH];

endmodule

// File: tb/tb_hft_order_gate.sv
// Self-checking bench for hft_order_gate: directed scenarios plus randomized decisions
// checked against a transaction-level model of the gate's rules.
module tb_hft_order_gate;

   localparam int DW   = 32;
   localparam int IDW  = 16;
   localparam int CW   = 16;
   localparam int MAXQ = 100;
   localparam int MAXP = 100;
   localparam int CD   = 4;
   localparam int TO   = 64;

   logic           ap_clk = 1'b0;
   logic           ap_rst_n = 1'b0;
   logic           dec_valid = 1'b0;
   logic [DW-1:0]  dec_action = '0, dec_price = '0, dec_qty = '0, current_position = '0;
   logic           ord_valid, ord_side;
   logic           ord_ready = 1'b0;
   logic [DW-1:0]  ord_price, ord_qty;
   logic [IDW-1:0] ord_id;
   logic           ack_valid = 1'b0;
   logic           busy;
   logic [CW-1:0]  sent_count, reject_count, drop_count, timeout_count;

   int checks = 0, failures = 0;
   int exp_sent = 0, exp_rej = 0, exp_drop = 0, exp_to = 0, exp_id = 0;

   always #5 ap_clk = ~ap_clk;

   hft_order_gate dut (
      .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .dec_valid(dec_valid), .dec_action(dec_action),
      .dec_price(dec_price), .dec_qty(dec_qty), .current_position(current_position),
      .ord_valid(ord_valid), .ord_ready(ord_ready), .ord_side(ord_side), .ord_price(ord_price),
      .ord_qty(ord_qty), .ord_id(ord_id), .ack_valid(ack_valid), .busy(busy),
      .sent_count(sent_count), .reject_count(reject_count), .drop_count(drop_count),
      .timeout_count(timeout_count)
   );

   function automatic bit model_pass(input int unsigned act, input int unsigned price,
                                     input int unsigned qty, input int pos);
      longint post;
      if (act != 1 && act != 2) return 1'b0;
      if (qty == 0 || qty > MAXQ) return 1'b0;
      if (price == 0) return 1'b0;
      post = (act == 1) ? longint'(pos) + longint'(qty) : longint'(pos) - longint'(qty);
      return (post <= MAXP) && (post >= -MAXP);
   endfunction

   // Full decision lifecycle; ack_wait < 0 means the exchange never acks.
   task automatic run_order(input int unsigned act, input int unsigned price, input int unsigned qty,
                            input int pos, input int ready_wait, input int ack_wait, input bit inject);
      bit pass;
      int n;
      pass = model_pass(act, price, qty, pos);
      @(negedge ap_clk);
      dec_action = act; dec_price = price; dec_qty = qty; current_position = pos; dec_valid = 1'b1;
      @(negedge ap_clk);
      dec_valid = 1'b0;
      checks++;
      if (ord_valid !== 1'b0) begin
         failures++; $display("FAIL latency_early ord_valid=%0b expected 0", ord_valid);
      end
      @(negedge ap_clk);
      if (!pass) begin
         if (act != 0) exp_rej++;
         checks++;
         if (ord_valid !== 1'b0 || busy !== 1'b0 || reject_count !== CW'(exp_rej) || sent_count !== CW'(exp_sent)) begin
            failures++;
            $display("FAIL reject act=%0d qty=%0d price=%0d pos=%0d: valid=%0b busy=%0b rej=%0d sent=%0d expected 0 0 %0d %0d",
                     act, qty, price, pos, ord_valid, busy, reject_count, sent_count, exp_rej, exp_sent);
         end
         return;
      end
      checks++;
      if (ord_valid !== 1'b1 || ord_side !== (act == 2) || ord_price !== price || ord_qty !== qty || ord_id !== IDW'(exp_id)) begin
         failures++;
         $display("FAIL payload valid=%0b side=%0b price=%0d qty=%0d id=%0d expected 1 %0b %0d %0d %0d",
                  ord_valid, ord_side, ord_price, ord_qty, ord_id, act == 2, price, qty, exp_id);
      end
      for (int i = 0; i < ready_wait; i++) begin
         if (inject && i == 0) begin
            dec_action = $urandom_range(1, 7); dec_price = $urandom; dec_qty = $urandom_range(1, 9);
            dec_valid = 1'b1; exp_drop++;
         end
         @(negedge ap_clk);
         dec_valid = 1'b0;
         checks++;
         if (ord_valid !== 1'b1 || ord_price !== price || ord_qty !== qty || ord_side !== (act == 2)) begin
            failures++;
            $display("FAIL backpressure_hold cycle=%0d valid=%0b price=%0d qty=%0d expected 1 %0d %0d",
                     i, ord_valid, ord_price, ord_qty, price, qty);
         end
      end
      ord_ready = 1'b1;
      @(negedge ap_clk);
      ord_ready = 1'b0;
      exp_sent++;
      exp_id = (exp_id + 1) % 65536;
      checks++;
      if (ord_valid !== 1'b0 || sent_count !== CW'(exp_sent) || ord_id !== IDW'(exp_id) || ord_price !== price) begin
         failures++;
         $display("FAIL handshake valid=%0b sent=%0d id=%0d price=%0d expected 0 %0d %0d %0d",
                  ord_valid, sent_count, ord_id, ord_price, exp_sent, exp_id, price);
      end
      if (ack_wait >= 0) begin
         repeat (ack_wait) @(negedge ap_clk);
         ack_valid = 1'b1;
         @(negedge ap_clk);
         ack_valid = 1'b0;
         checks++;
         if (timeout_count !== CW'(exp_to) || busy !== 1'b1) begin
            failures++;
            $display("FAIL ack wait=%0d timeouts=%0d busy=%0b expected %0d 1", ack_wait, timeout_count, busy, exp_to);
         end
      end else begin
         n = 0;
         while (timeout_count === CW'(exp_to) && n < 200) begin
            @(negedge ap_clk);
            n++;
         end
         exp_to++;
         checks++;
         if (n != TO || timeout_count !== CW'(exp_to)) begin
            failures++;
            $display("FAIL timeout cycles=%0d count=%0d expected %0d %0d", n, timeout_count, TO, exp_to);
         end
      end
      n = 0;
      while (busy === 1'b1 && n < 50) begin
         n++;
         if (inject && n == CD) begin
            dec_action = 1; dec_price = 7; dec_qty = 1; current_position = 0;
            dec_valid = 1'b1; exp_drop++;
         end
         @(negedge ap_clk);
         dec_valid = 1'b0;
      end
      checks++;
      if (n != CD) begin
         failures++; $display("FAIL cooldown busy_cycles=%0d expected %0d", n, CD);
      end
      @(negedge ap_clk);
      checks++;
      if (busy !== 1'b0 || drop_count !== CW'(exp_drop) || reject_count !== CW'(exp_rej) ||
          sent_count !== CW'(exp_sent) || timeout_count !== CW'(exp_to)) begin
         failures++;
         $display("FAIL post_order busy=%0b drop=%0d rej=%0d sent=%0d to=%0d expected 0 %0d %0d %0d %0d",
                  busy, drop_count, reject_count, sent_count, timeout_count, exp_drop, exp_rej, exp_sent, exp_to);
      end
      $display("order act=%0d price=%0d qty=%0d pos=%0d ready_wait=%0d ack_wait=%0d id_next=%0d",
               act, price, qty, pos, ready_wait, ack_wait, exp_id);
   endtask

   task automatic test_reset();
      repeat (3) @(negedge ap_clk);
      ap_rst_n = 1'b1;
      @(negedge ap_clk);
      checks++;
      if (ord_valid !== 0 || ord_side !== 0 || ord_price !== 0 || ord_qty !== 0 || ord_id !== 0 || busy !== 0 ||
          sent_count !== 0 || reject_count !== 0 || drop_count !== 0 || timeout_count !== 0) begin
         failures++;
         $display("FAIL reset_state valid=%0b id=%0d busy=%0b sent=%0d rej=%0d expected all zero",
                  ord_valid, ord_id, busy, sent_count, reject_count);
      end
      $display("reset checked");
   endtask

   task automatic test_nominal();
      run_order(1, 80299, 50, 0, 0, 3, 1'b0);
   endtask

   task automatic test_position_limit();
      run_order(1, 1000, 50, 80, 0, 0, 1'b0);
      run_order(2, 1000, 50, 80, 0, 0, 1'b0);
   endtask

   task automatic test_checks();
      run_order(1, 500, 0, 0, 0, 0, 1'b0);
      run_order(1, 500, 101, 0, 0, 0, 1'b0);
      run_order(1, 0, 10, 0, 0, 0, 1'b0);
      run_order(3, 500, 10, 0, 0, 0, 1'b0);
      run_order(0, 500, 10, 0, 0, 0, 1'b0);
      run_order(2, 500, 100, 0, 0, 63, 1'b0);
      checks++;
      if (reject_count !== CW'(exp_rej) || drop_count !== CW'(exp_drop)) begin
         failures++;
         $display("FAIL check_counts rej=%0d drop=%0d expected %0d %0d", reject_count, drop_count, exp_rej, exp_drop);
      end
   endtask

   task automatic test_backpressure_drop();
      int sent_before;
      sent_before = exp_sent;
      run_order(1, 4242, 10, 0, 5, 2, 1'b1);
      checks++;
      if (sent_count !== CW'(sent_before + 1)) begin
         failures++; $display("FAIL single_order sent=%0d expected %0d", sent_count, sent_before + 1);
      end
   endtask

   task automatic test_timeout();
      run_order(2, 777, 20, 0, 0, -1, 1'b0);
      run_order(1, 778, 20, 0, 0, 1, 1'b0);
   endtask

   task automatic test_random();
      int unsigned act, price, qty;
      int pos, aw, r;
      for (int k = 0; k < 30; k++) begin
         r = $urandom_range(0, 9);
         act = (r == 0) ? 0 : (r <= 4) ? 1 : (r <= 8) ? 2 : $urandom_range(3, 255);
         qty = $urandom_range(0, 110);
         price = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 100000);
         pos = int'($urandom_range(0, 240)) - 120;
         r = $urandom_range(0, 9);
         aw = (r == 0) ? -1 : (r == 1) ? 63 : int'($urandom_range(0, 20));
         run_order(act, price, qty, pos, $urandom_range(0, 3), aw, 1'($urandom_range(0, 1)));
      end
      checks++;
      if (sent_count !== CW'(exp_sent) || reject_count !== CW'(exp_rej) || ord_id !== IDW'(exp_id)) begin
         failures++;
         $display("FAIL random_totals sent=%0d rej=%0d id=%0d expected %0d %0d %0d",
                  sent_count, reject_count, ord_id, exp_sent, exp_rej, exp_id);
      end
   endtask

   task automatic test_reset_mid();
      @(negedge ap_clk);
      dec_action = 1; dec_price = 999; dec_qty = 5; current_position = 0; dec_valid = 1'b1;
      @(negedge ap_clk);
      dec_valid = 1'b0;
      @(negedge ap_clk);
      ord_ready = 1'b1;
      @(negedge ap_clk);
      ord_ready = 1'b0;
      repeat (3) @(negedge ap_clk);
      #2 ap_rst_n = 1'b0;
      #1;
      checks++;
      if (ord_valid !== 0 || ord_side !== 0 || ord_price !== 0 || ord_qty !== 0 || ord_id !== 0 || busy !== 0 ||
          sent_count !== 0 || reject_count !== 0 || drop_count !== 0 || timeout_count !== 0) begin
         failures++;
         $display("FAIL async_reset price=%0d id=%0d busy=%0b sent=%0d rej=%0d to=%0d expected all zero",
                  ord_price, ord_id, busy, sent_count, reject_count, timeout_count);
      end
      exp_sent = 0; exp_rej = 0; exp_drop = 0; exp_to = 0; exp_id = 0;
      @(negedge ap_clk);
      ap_rst_n = 1'b1;
      run_order(1, 80299, 50, 0, 0, 1, 1'b0);
   endtask

   initial begin
      #3_000_000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_nominal();
      test_position_limit();
      test_checks();
      test_backpressure_drop();
      test_timeout();
      test_random();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
